serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 95 +++++++++
 tb/tb_serial_add_sub.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor, DIGIT bits per clock with a registered carry
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request, sampled only while busy=0
//   a, b, cin, sub    operands, carry/borrow-in and mode; captured on an accepted start
//   busy              high while digits are being processed
//   done              one-cycle pulse when sum/cout/ovf become valid
//   sum, cout, ovf    result, raw carry out of the MSB, signed overflow; held until the next result
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cmsb, r_busy, r_done, r_cout, r_ovf;
  logic [DIGIT:0]   w_slice;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc;
  assign w_slice = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  // top result bit is a^b^c_in, so the carry into it can be recovered from the slice output
  assign w_cmsb  = w_slice[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
  assign w_acc   = (r_acc >> DIGIT) | (WIDTH'(w_slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // one extra cycle after the last digit publishes the result
          if (r_cnt == CW'(N)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= r_acc;
            r_cout  <= r_carry;
            r_ovf   <= r_cmsb ^ r_carry;
          end else begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_acc   <= w_acc;
            r_carry <= w_slice[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CW'(N - 1)) r_cmsb <= w_cmsb;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and randomized checks of serial_add_sub over several WIDTH/DIGIT sets
module tb_serial_add_sub;
  localparam int NI = 6;
  localparam int WV [NI] = '{8, 8, 16, 16, 16, 16};
  localparam int NV [NI] = '{8, 2, 16, 8, 4, 1};
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [NI];
  logic [15:0] a_v [NI];
  logic [15:0] b_v [NI];
  logic        cin_v [NI];
  logic        sub_v [NI];
  logic        busy_v [NI];
  logic        done_v [NI];
  logic [15:0] sum_v [NI];
  logic        cout_v [NI];
  logic        ovf_v [NI];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WW = g < 2 ? 8 : 16;
    localparam int DD = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 1 : g == 3 ? 2 : g == 4 ? 4 : 16;
    logic [WW-1:0] s;
    serial_add_sub #(.WIDTH(WW), .DIGIT(DD)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .a(a_v[g][WW-1:0]), .b(b_v[g][WW-1:0]),
      .cin(cin_v[g]), .sub(sub_v[g]), .busy(busy_v[g]), .done(done_v[g]), .sum(s),
      .cout(cout_v[g]), .ovf(ovf_v[g]));
    assign sum_v[g] = 16'(s);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic su,
                                output logic [15:0] s, output logic co, output logic ov);
    longint m  = longint'(1) << w;
    longint ua = longint'(av) & (m - 1);
    longint ub = longint'(bv) & (m - 1);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint c  = longint'(ci);
    longint ru = su ? ua - ub - c : ua + ub + c;
    longint rs = su ? sa - sb - c : sa + sb + c;
    s  = 16'(ru & (m - 1));
    co = su ? (ru >= 0) : (ru >= m);
    ov = (rs < -(m / 2)) || (rs >= m / 2);
  endfunction
  task automatic start_op(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic ci, input logic su);
    @(negedge clk);
    a_v[k] = av; b_v[k] = bv; cin_v[k] = ci; sub_v[k] = su; start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
  endtask
  task automatic wait_done(input int k, output int n);
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (done_v[k]) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic chk_res(input string tag, input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic su);
    logic [15:0] es;
    logic        ec, eo;
    model(WV[k], av, bv, ci, su, es, ec, eo);
    chk({tag, "_sum"}, 32'(sum_v[k]), 32'(es));
    chk({tag, "_cout"}, 32'(cout_v[k]), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf_v[k]), 32'(eo));
  endtask
  initial begin
    int n;
    int lat [NI];
    logic [15:0] ra [NI], rb [NI];
    logic rc [NI], rs [NI];
    logic seen;
    for (int k = 0; k < NI; k++) begin
      start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy", 32'(busy_v[k]), 0);
      chk("rst_done", 32'(done_v[k]), 0);
      chk("rst_sum", 32'(sum_v[k]), 0);
      chk("rst_cout_ovf", {30'd0, cout_v[k], ovf_v[k]}, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    // 8-bit, one bit per cycle
    start_op(0, 16'h7F, 16'h01, 1'b0, 1'b0);
    #1 chk("busy_after_accept", 32'(busy_v[0]), 1);
    wait_done(0, n);
    chk("lat_d1", n, 9);
    chk("busy_at_done", 32'(busy_v[0]), 0);
    chk_res("add_7f_01", 0, 16'h7F, 16'h01, 1'b0, 1'b0);
    chk("add_7f_01_const", {sum_v[0], 14'd0, cout_v[0], ovf_v[0]}, {16'h0080, 16'h0001});
    @(posedge clk) #1 chk("done_pulse", 32'(done_v[0]), 0);
    chk("sum_hold", 32'(sum_v[0]), 32'h80);
    start_op(0, 16'h05, 16'h07, 1'b0, 1'b1);
    wait_done(0, n);
    chk("sub_5_7_const", {sum_v[0], 14'd0, cout_v[0], ovf_v[0]}, {16'h00FE, 16'h0000});
    start_op(0, 16'h80, 16'h01, 1'b0, 1'b1);
    wait_done(0, n);
    chk("sub_80_1_const", {sum_v[0], 14'd0, cout_v[0], ovf_v[0]}, {16'h007F, 16'h0003});
    // 8-bit, four bits per cycle
    start_op(1, 16'hFF, 16'h01, 1'b1, 1'b0);
    wait_done(1, n);
    chk("lat_d4", n, 3);
    chk("add_ff_01_c_const", {sum_v[1], 14'd0, cout_v[1], ovf_v[1]}, {16'h0001, 16'h0002});
    // start during RUN is ignored
    start_op(0, 16'h12, 16'h34, 1'b1, 1'b0);
    @(negedge clk);
    a_v[0] = 16'hAA; b_v[0] = 16'hBB; sub_v[0] = 1'b1; start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    wait_done(0, n);
    chk("lat_ignore", n, 8);
    chk_res("ignore", 0, 16'h12, 16'h34, 1'b1, 1'b0);
    // start in the DONE cycle is accepted
    start_op(0, 16'h9C, 16'h3B, 1'b0, 1'b1);
    wait_done(0, n);
    chk_res("b2b_first", 0, 16'h9C, 16'h3B, 1'b0, 1'b1);
    start_op(0, 16'hC8, 16'h64, 1'b1, 1'b0);
    wait_done(0, n);
    chk("lat_b2b", n, 9);
    chk_res("b2b_second", 0, 16'hC8, 16'h64, 1'b1, 1'b0);
    // asynchronous reset mid-RUN, between edges
    start_op(0, 16'h55, 16'h66, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(sum_v[0]), 0);
    chk("arst_busy_done", {30'd0, busy_v[0], done_v[0]}, 0);
    chk("arst_cout_ovf", {30'd0, cout_v[0], ovf_v[0]}, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 seen = seen | done_v[0];
    end
    chk("arst_no_done", 32'(seen), 0);
    start_op(0, 16'h3C, 16'hE7, 1'b1, 1'b1);
    wait_done(0, n);
    chk("lat_after_rst", n, 9);
    chk_res("after_rst", 0, 16'h3C, 16'hE7, 1'b1, 1'b1);
    // random sweep, four 16-bit instances run in parallel
    for (int it = 0; it < 2500; it++) begin
      @(negedge clk);
      for (int k = 2; k < NI; k++) begin
        ra[k] = 16'($urandom); rb[k] = 16'($urandom);
        rc[k] = 1'($urandom); rs[k] = 1'($urandom);
        a_v[k] = ra[k]; b_v[k] = rb[k]; cin_v[k] = rc[k]; sub_v[k] = rs[k]; start_v[k] = 1'b1;
        lat[k] = 0;
      end
      @(posedge clk);
      #1;
      for (int k = 2; k < NI; k++) begin
        start_v[k] = 1'b0;
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom);
      end
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk);
        #1;
        for (int k = 2; k < NI; k++)
          if (done_v[k] && lat[k] == 0) begin
            lat[k] = i;
            chk_res("rand", k, ra[k], rb[k], rc[k], rs[k]);
          end
      end
      for (int k = 2; k < NI; k++) chk("rand_lat", lat[k], NV[k] + 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
